// File: rtl/vital_pkg.sv
// Shared types and constants for the vital_alert_tx emergency-alert transmitter.
package vital_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_CLEAR = 2'd2
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Frame lengths in bytes: header, dose, [seq,] checksum.
  localparam int unsigned FRAME_LEN_BASE = 3;
  localparam int unsigned FRAME_LEN_SEQ  = 4;

endpackage

// File: rtl/vital_confirm_ctr.sv
// Consecutive-emergency run counter: counts hit samples, clears on a miss or on clr_i,
// and pulses tc_o combinationally on the sample that completes the run.
module vital_confirm_ctr #(
  parameter int unsigned CNT_MAX = 4,
  localparam int unsigned W = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic hit_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && hit_i && (cnt_q == W'(CNT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // The terminal sample restarts the run so a later confirmation starts from zero.
      if (!hit_i || tc_o) cnt_d = '0;
      else                cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vital_alert_tx.sv
// Emergency-alert transmitter: confirms a run of emergency samples, sends a checksummed
// frame over valid/ready, and holds alarm until cleared. Optional macro: VITAL_ALERT_SEQ_EN.
module vital_alert_tx
  import vital_pkg::*;
#(
  parameter int unsigned CONFIRM_CNT = 4,
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic       emerg,
  input  logic [7:0] o2_dose,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       alarm,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; while tx_valid
  // is high and tx_ready low, tx_valid and tx_data hold their values unchanged.

`ifdef VITAL_ALERT_SEQ_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_SEQ;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] dose_q, dose_d;
  logic [7:0] checksum;
  logic       confirm;
  logic       xfer;
  logic       last_xfer;

  assign xfer      = tx_valid && tx_ready;
  assign last_xfer = xfer && (idx_q == LAST_IDX);
  assign dbg_state = state_q;

  vital_confirm_ctr #(
    .CNT_MAX (CONFIRM_CNT)
  ) u_confirm_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != ST_IDLE),
    .en_i  (sample_valid && (state_q == ST_IDLE)),
    .hit_i (emerg),
    .tc_o  (confirm)
  );

`ifdef VITAL_ALERT_SEQ_EN
  logic [7:0] seq_q, seq_d;

  assign checksum = HEADER ^ dose_q ^ seq_q;

  always_comb begin
    seq_d = seq_q;
    if (state_q == ST_SEND && last_xfer) seq_d = seq_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= 8'h00;
    else        seq_q <= seq_d;
  end
`else
  assign checksum = HEADER ^ dose_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (confirm) state_d = ST_SEND;
      ST_SEND:       if (last_xfer) state_d = ST_WAIT_CLEAR;
      ST_WAIT_CLEAR: if (sample_valid && !emerg) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    tx_valid = (state_q == ST_SEND);
    busy     = (state_q == ST_SEND);
    alarm    = (state_q != ST_IDLE);
    tx_data  = 8'h00;
    if (state_q == ST_SEND) begin
      unique case (idx_q)
        2'd0:    tx_data = HEADER;
        2'd1:    tx_data = dose_q;
`ifdef VITAL_ALERT_SEQ_EN
        2'd2:    tx_data = seq_q;
        2'd3:    tx_data = checksum;
`else
        2'd2:    tx_data = checksum;
        2'd3:    tx_data = 8'h00;
`endif
        default: tx_data = 8'h00;
      endcase
    end
  end

  // Byte index and latched dose.
  always_comb begin
    idx_d  = idx_q;
    dose_d = dose_q;
    if (state_q == ST_IDLE && confirm) dose_d = o2_dose;
    if (state_q != ST_SEND)            idx_d  = 2'd0;
    else if (last_xfer)                idx_d  = 2'd0;
    else if (xfer)                     idx_d  = idx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      dose_q <= 8'h00;
    end else begin
      idx_q  <= idx_d;
      dose_q <= dose_d;
    end
  end

endmodule

// File: tb/tb_vital_alert_tx.sv
// Directed self-checking bench for vital_alert_tx (CONFIRM_CNT=4, HEADER=A5);
// follows VITAL_ALERT_SEQ_EN for the expected frame layout.
module tb_vital_alert_tx;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic       emerg;
  logic [7:0] o2_dose;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       alarm;
  logic       busy;
  logic [1:0] dbg_state;

`ifdef VITAL_ALERT_SEQ_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;
  logic [7:0] frame[4];
  logic       prev_stall;
  logic [7:0] prev_data;

  vital_alert_tx #(
    .CONFIRM_CNT (4),
    .HEADER      (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .emerg        (emerg),
    .o2_dose      (o2_dose),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .alarm        (alarm),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Builds the expected frame for a dose (hand-derived layout) and queues it.
  task automatic push_frame(input logic [7:0] d);
    frame[0] = 8'hA5;
    frame[1] = d;
`ifdef VITAL_ALERT_SEQ_EN
    frame[2] = exp_seq;
    frame[3] = 8'hA5 ^ d ^ exp_seq;
    exp_seq  = exp_seq + 8'd1;
`else
    frame[2] = 8'hA5 ^ d;
    frame[3] = 8'h00;
`endif
    for (int i = 0; i < FL; i++) exp_q.push_back(frame[i]);
  endtask

  // Driver tasks: called at posedge+1, return at the next posedge+1.
  task automatic sample(input logic e, input logic [7:0] d);
    sample_valid = 1'b1;
    emerg        = e;
    o2_dose      = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    emerg        = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: inputs settle at posedge+1, so valid&&ready at negedge is a transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
        else                   check("frame_byte", tx_data, exp_q.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; emerg = 1'b0; o2_dose = 8'h00; tx_ready = 1'b0;
    exp_seq = 8'h00; prev_stall = 1'b0; prev_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_alarm", alarm, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    idle_cycles(2);

    // Basic confirm with back-to-back bytes.
    push_frame(8'h3C);
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 8'h3C);
      check("pre_confirm_alarm", alarm, 0);
    end
    sample(1'b1, 8'h3C);
    check("confirm_alarm", alarm, 1);
    check("confirm_busy", busy, 1);
    for (int i = 0; i < FL; i++) begin
      check("b2b_valid", tx_valid, 1);
      check("b2b_data", tx_data, frame[i]);
      idle_cycles(1);
    end
    check("after_frame_valid", tx_valid, 0);
    check("after_frame_busy", busy, 0);
    check("after_frame_alarm", alarm, 1);
    sample(1'b0, 8'h00);
    check("clear_alarm", alarm, 0);

    // Broken run never confirms.
    for (int i = 0; i < 3; i++) sample(1'b1, 8'h55);
    sample(1'b0, 8'h55);
    for (int i = 0; i < 3; i++) sample(1'b1, 8'h55);
    check("broken_run_alarm", alarm, 0);
    check("broken_run_valid", tx_valid, 0);
    sample(1'b0, 8'h00);

    // Stalled frame: 5 stall cycles per byte.
    tx_ready = 1'b0;
    push_frame(8'h10);
    for (int i = 0; i < 4; i++) sample(1'b1, 8'h10);
    for (int b = 0; b < FL; b++) begin
      repeat (5) begin
        check("stall_busy", busy, 1);
        check("stall_byte", tx_data, frame[b]);
        sample(1'b0, 8'h00);
      end
      tx_ready = 1'b1;
      idle_cycles(1);
      tx_ready = 1'b0;
    end
    check("stall_end_busy", busy, 0);
    check("stall_end_alarm", alarm, 1);
    tx_ready = 1'b1;

    // Held emergency does not resend; clear then reconfirm.
    sample(1'b0, 8'h00);
    push_frame(8'h3C);
    for (int i = 0; i < 4; i++) sample(1'b1, 8'h3C);
    idle_cycles(FL);
    for (int i = 0; i < 5; i++) sample(1'b1, 8'h77);
    check("hold_no_resend", tx_valid, 0);
    check("hold_alarm", alarm, 1);
    sample(1'b0, 8'h00);
    check("hold_cleared", alarm, 0);
    push_frame(8'h3C);
    for (int i = 0; i < 4; i++) sample(1'b1, 8'h3C);
    check("resend_valid", tx_valid, 1);
    idle_cycles(FL);
    check("resend_done", busy, 0);
    sample(1'b0, 8'h00);
    check("resend_queue_empty", exp_q.size(), 0);

    // Reset after the header transfer abandons the frame.
    push_frame(8'h3C);
    for (int i = 0; i < 4; i++) sample(1'b1, 8'h3C);
    idle_cycles(1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_alarm", alarm, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    exp_seq = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);
    push_frame(8'h3C);
    for (int i = 0; i < 4; i++) sample(1'b1, 8'h3C);
    for (int i = 0; i < FL; i++) begin
      check("fresh_data", tx_data, frame[i]);
      idle_cycles(1);
    end
    check("fresh_done", tx_valid, 0);
    sample(1'b0, 8'h00);
    idle_cycles(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vital_alert_tx.md
# vital_alert_tx

Emergency-alert transmitter for the smart-ring vitals path. Consumes the per-sample emergency flag and oxygen-dose byte produced by the vitals evaluation logic, confirms an emergency only after a run of consecutive emergency samples, then sends a checksummed alert frame byte-by-byte over a valid/ready link to the radio/phone interface. It holds an alarm output until the emergency clears.

## Interface
- CONFIRM_CNT, 4: consecutive emergency samples required to confirm; legal range 1..15.
- HEADER, 8'hA5: first byte of every frame.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- sample_valid  input  1  one-cycle strobe: emerg and o2_dose are valid this cycle.
- emerg  input  1  emergency flag for the current sample.
- o2_dose  input  8  unsigned oxygen-dose value for the current sample.
- tx_ready  input  1  downstream can accept a byte.
- tx_valid  output  1  tx_data holds a frame byte.
- tx_data  output  8  frame byte.
- alarm  output  1  emergency confirmed and not yet cleared.
- busy  output  1  high in SEND.

## Operation
- States: IDLE, SEND, WAIT_CLEAR.
- IDLE, count logic:
  - An accepted sample with emerg=1 increments the run counter, which is $clog2(CONFIRM_CNT+1) bits wide.
  - An accepted sample with emerg=0 clears the counter to 0.
- Confirmation: the emerg=1 sample that brings the counter to CONFIRM_CNT confirms the emergency.
  - That sample's o2_dose is latched as the frame dose.
  - alarm is set, the counter is cleared, and the state goes to SEND.
- SEND: frame bytes are sent in order HEADER, dose, checksum.
  - checksum = XOR of all preceding frame bytes.
  - A byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid stay stable until that transfer.
  - After the last byte transfers, the state goes to WAIT_CLEAR.
- SEND ignores samples entirely: no latching, no counting, no clear detection.
- WAIT_CLEAR:
  - An accepted sample with emerg=0 clears alarm and returns to IDLE with the counter at 0.
  - emerg=1 samples are ignored, so there is no re-send until an emergency has been cleared and then re-confirmed.
- busy = (state == SEND).
- Reset mid-frame: the frame is abandoned. No partial-frame resumption.

## Timing
- Reset values:
  - tx_valid=0, tx_data=8'h00, alarm=0, busy=0.
  - state=IDLE, counter=0, dose register=0.
- Latency:
  - alarm, busy and tx_valid (carrying HEADER) all rise on the edge after the confirming sample's cycle.
  - Each subsequent byte is presented on the edge after the previous transfer.
  - Minimum frame duration is 3 cycles with tx_ready held high.
- tx_valid is continuous within a frame. It never drops between bytes and deasserts on the edge following the last transfer.
- tx_ready may toggle arbitrarily. The bench checks that tx_data is stable across stalls.
- A clearing sample in WAIT_CLEAR drops alarm on the next edge.
- A sample in the same cycle as the last-byte transfer is ignored (the state is still SEND).

## Configuration
- VITAL_ALERT_SEQ_EN defined:
  - The frame is HEADER, dose, seq, checksum, where checksum is the XOR over all three preceding bytes.
  - seq is an 8-bit counter, reset to 0, incremented (wrapping 8'hFF→8'h00) after each completed frame.
- Not defined: 3-byte frame as in Operation; no seq register.

## Structure
- Shared package vital_pkg holds:
  - the state enum;
  - HEADER default;
  - frame-length constants: 3 base, 4 with seq.
- Natural sub-module: vital_confirm_ctr, the consecutive-sample run counter with clear and a terminal-count pulse.
- Framing and the handshake stay in the top level.

## Test plan
- Reset, then CONFIRM_CNT=4, four emerg=1 samples with o2_dose=8'h3C, tx_ready=1 → frame A5, 3C, 99 on 3 consecutive cycles; alarm=1 one cycle after the 4th sample.
- Three emerg=1 samples, one emerg=0, three emerg=1 → no frame, alarm stays 0.
- Confirm with dose 8'h10; tx_ready low for 5 cycles on each byte → A5, 10, B5 with data stable during stalls; busy high throughout.
- After a frame, emerg=1 samples continue → no second frame. One emerg=0 sample → alarm falls. Four emerg=1 → second frame sent.
- Assert rst_n low after the header transfer → all outputs at reset values immediately; a new confirmation yields a full fresh frame.
- With VITAL_ALERT_SEQ_EN and dose 8'h3C → first frame A5, 3C, 00, 99; second frame A5, 3C, 01, 98.
